spi_slave_ctrl: RTL

Serial-to-parallel front end for the single-port-addressed RAM. Receives 10-bit command/data frames on MOSI while SS_n is low, presents each completed frame as rx_data with a one-cycle rx_valid strobe, and, for read-data commands, waits for tx_valid from the RAM and shifts the returned byte out on MISO MSB-first. Sits directly upstream of the RAM: rx_data/rx_valid drive the RAM's din/rx_valid; the RAM's dout/tx_valid return as tx_data/tx_valid.

---
 rtl/spi_slave_pkg.sv | 19 +
 rtl/spi_slave_ctrl_if.sv | 22 ++
 rtl/spi_tx_serializer.sv | 55 +++++
 rtl/spi_slave_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end of the single-port RAM.
package spi_slave_pkg;
    localparam int FRAME_W  = 10;
    localparam int DATA_W   = 8;
    localparam int RX_CNT_W = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;
endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Serial pins plus the RAM-facing frame/read-byte handshake of the SPI slave.
interface spi_slave_ctrl_if
    import spi_slave_pkg::*;
();
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_tx_serializer.sv
// Latches one read byte on load and shifts it out MSB-first; done stays set until clear.
module spi_tx_serializer
    import spi_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              active_reg;
    logic              done_reg;
    logic              miso_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            active_reg  <= 1'b0;
            done_reg    <= 1'b0;
            miso_reg    <= 1'b0;
        end else if (clear) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            active_reg  <= 1'b0;
            done_reg    <= 1'b0;
            miso_reg    <= 1'b0;
        end else if (active_reg) begin
            miso_reg    <= shift_reg[DATA_W-1];
            shift_reg   <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                active_reg <= 1'b0;
                done_reg   <= 1'b1;
            end
        end else begin
            // Line idles low; a finished byte blocks any reload until the frame ends.
            miso_reg <= 1'b0;
            if (load && !done_reg) begin
                shift_reg   <= data;
                bit_cnt_reg <= '0;
                active_reg  <= 1'b1;
            end
        end
    end

    assign miso = miso_reg;
    assign done = done_reg;
endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave: receives 10-bit command frames for the RAM and returns read bytes on MISO.
module spi_slave_ctrl
    import spi_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_ctrl_if.slave bus
);
    state_t               state_reg, state_next;
    logic [FRAME_W-1:0]   shift_reg, shift_next, rx_data_reg;
    logic [RX_CNT_W-1:0]  bit_cnt_reg;
    logic                 frame_done_reg, rx_valid_reg, rd_addr_seen_reg;
    logic                 capture, complete;
    logic                 ser_load, ser_clear, ser_done;

    assign shift_next = {shift_reg[FRAME_W-2:0], bus.MOSI};

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!bus.SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_next = IDLE;
                end else begin
                    capture = 1'b1;
                    if (!bus.MOSI)            state_next = WRITE;
                    else if (rd_addr_seen_reg) state_next = READ_DATA;
                    else                       state_next = READ_ADD;
                end
            end
            default: begin
                // The last bit still lands if SS_n rises on the very same edge.
                if (!frame_done_reg && bit_cnt_reg == RX_CNT_W'(FRAME_W - 1)) begin
                    capture  = 1'b1;
                    complete = 1'b1;
                end else if (!frame_done_reg && !bus.SS_n) begin
                    capture = 1'b1;
                end
                if (bus.SS_n) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg        <= '0;
            rx_data_reg      <= '0;
            bit_cnt_reg      <= '0;
            frame_done_reg   <= 1'b0;
            rx_valid_reg     <= 1'b0;
            rd_addr_seen_reg <= 1'b0;
        end else begin
            rx_valid_reg <= complete;
            if (state_next == IDLE) begin
                bit_cnt_reg    <= '0;
                frame_done_reg <= 1'b0;
            end else if (capture) begin
                if (complete) frame_done_reg <= 1'b1;
                else          bit_cnt_reg    <= bit_cnt_reg + 1'b1;
            end
            if (capture)  shift_reg   <= shift_next;
            if (complete) rx_data_reg <= shift_next;
            if (complete && state_reg == READ_ADD) rd_addr_seen_reg <= 1'b1;
            else if (ser_done)                     rd_addr_seen_reg <= 1'b0;
        end
    end

    assign ser_load  = (state_reg == READ_DATA) && frame_done_reg && bus.tx_valid && !bus.SS_n;
    assign ser_clear = bus.SS_n || (state_reg == IDLE);

    spi_tx_serializer u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ser_clear),
        .load  (ser_load),
        .data  (bus.tx_data),
        .miso  (bus.MISO),
        .done  (ser_done)
    );

    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
endmodule
